// File: rtl/fifo_flex.sv
// fifo_flex: single-clock FIFO with arbitrary (non power-of-two) depth,
// programmable almost-full/almost-empty thresholds, an occupancy count,
// a synchronous flush and sticky overflow/underflow flags.
// Optional feature macro: FIFO_FLEX_PARITY_EN stores an even-parity bit per
// word and raises a sticky parity_err when a popped word fails its check.
module fifo_flex #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 3,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       w_valid,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       r_ready,
  output logic [WIDTH-1:0]           data_out,
  output logic                       fifo_full,
  output logic                       fifo_empty,
  output logic                       pre_full,
  output logic                       pre_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow,
  output logic                       parity_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
`ifdef FIFO_FLEX_PARITY_EN
  localparam int SW = WIDTH + 1;
`else
  localparam int SW = WIDTH;
`endif

  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_THRESH);

  logic [DEPTH-1:0][SW-1:0] mem_q;
  logic [PW-1:0]            rptr_q, rptr_d;
  logic [PW-1:0]            wptr_q, wptr_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     ovf_q, ovf_d;
  logic                     unf_q, unf_d;
  logic                     primed_q, primed_d;
  logic                     wr_acc, rd_acc;
  logic [SW-1:0]            head;
  logic [SW-1:0]            store_word;

  // Flags decode straight from the registered count, so they only move after an edge or reset.
  assign fifo_full  = (cnt_q == FULL_CNT);
  assign fifo_empty = (cnt_q == '0);
  assign pre_full   = (cnt_q >= AF_CNT);
  assign pre_empty  = (cnt_q <= AE_CNT);
  assign count      = cnt_q;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;

  // Flush wins over any transfer in the same cycle, so neither side is accepted then.
  assign wr_acc = w_valid & ~fifo_full & ~flush;
  assign rd_acc = r_ready & ~fifo_empty & ~flush;

  // Show-ahead head word; the memory is never cleared, so data_out is held at
  // zero until the first accepted write after reset.
  assign head     = mem_q[rptr_q];
  assign data_out = primed_q ? head[WIDTH-1:0] : '0;

`ifdef FIFO_FLEX_PARITY_EN
  logic perr_q;
  logic par_bad;

  assign store_word = {^data_in, data_in};
  assign par_bad    = (^head[WIDTH-1:0]) != head[WIDTH];
  assign parity_err = perr_q;

  // Sticky parity error: set when a popped word fails its check, cleared only by flush or reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perr_q <= 1'b0;
    end else if (flush) begin
      perr_q <= 1'b0;
    end else if (rd_acc && par_bad) begin
      perr_q <= 1'b1;
    end
  end
`else
  assign store_word = data_in;
  assign parity_err = 1'b0;
`endif

  // Storage array has no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wptr_q] <= store_word;
    end
  end

  // Next-state for pointers, occupancy and sticky flags; pointers wrap at DEPTH-1.
  always_comb begin
    rptr_d   = rptr_q;
    wptr_d   = wptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    primed_d = primed_q;
    if (flush) begin
      rptr_d = '0;
      wptr_d = '0;
      cnt_d  = '0;
      ovf_d  = 1'b0;
      unf_d  = 1'b0;
    end else begin
      if (w_valid && fifo_full) begin
        ovf_d = 1'b1;
      end
      if (r_ready && fifo_empty) begin
        unf_d = 1'b1;
      end
      if (wr_acc) begin
        wptr_d   = (wptr_q == LAST_PTR) ? '0 : wptr_q + 1'b1;
        primed_d = 1'b1;
      end
      if (rd_acc) begin
        rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + 1'b1;
      end
      if (wr_acc && !rd_acc) begin
        cnt_d = cnt_q + 1'b1;
      end else if (rd_acc && !wr_acc) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // Control state registers; reset discards all contents immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rptr_q   <= '0;
      wptr_q   <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      rptr_q   <= rptr_d;
      wptr_q   <= wptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      primed_q <= primed_d;
    end
  end

endmodule
